// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings, state type and request helpers for the memory access sequencer
// Exception vector bytes live at the top of the 256-byte RAM.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam logic [7:0] VEC_253 = 8'd253;
   localparam logic [7:0] VEC_254 = 8'd254;
   localparam logic [7:0] VEC_255 = 8'd255;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_FIN,
      ST_ERR
   } state_t;

   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      case (sz)
         SZ_BYTE: return 3'd1;
         SZ_HALF: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // Reserved size or a half/word that does not sit on its natural boundary.
   function automatic logic req_bad(input logic [1:0] sz, input logic [1:0] a_lo);
      return (sz == SZ_RSVD) ||
             (sz == SZ_HALF && a_lo[0]) ||
             (sz == SZ_WORD && a_lo != 2'b00);
   endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sign/zero extension of an assembled big-endian load value
// Byte and half results sit in the low bits of value; word results pass through.
module load_extend
   import mem_pkg::*;
(
   input  logic [31:0] value,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic [31:0] result
);

   always_comb begin
      result = value;
      case (size)
         SZ_BYTE: result = {{24{sign_ext & value[7]}}, value[7:0]};
         SZ_HALF: result = {{16{sign_ext & value[15]}}, value[15:0]};
         default: result = value;
      endcase
   end

endmodule

// File: rtl/mem_access_seq.sv
// rtl/mem_access_seq.sv - splits word/half/byte requests into single-byte RAM beats
// Loads are assembled MSB first from a one-cycle-latency byte RAM.
module mem_access_seq
   import mem_pkg::*;
#(
   parameter int ADDR_BITS = 8,
   parameter int RD_LAT    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req,
   input  logic                 we,
   input  logic [1:0]           size,
   input  logic                 sign_ext,
   input  logic [31:0]          addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [7:0]           mem_wdata,
   output logic                 mem_we,
   input  logic [7:0]           mem_rdata
);

   if (RD_LAT != 1) begin : g_rd_lat_check
      $error("mem_access_seq supports RD_LAT = 1 only");
   end

   state_t                state, state_nx;
   logic [1:0]            beat;
   logic [ADDR_BITS-1:0]  base;
   logic [1:0]            r_size;
   logic                  r_we;
   logic                  r_sx;
   logic [31:0]           r_wdata;
   logic [23:0]           shreg;
   logic [31:0]           ext_val;
   logic [2:0]            nbytes;
   logic                  last_beat;
   logic [1:0]            wsel;
   logic                  unused_addr_hi;

   assign unused_addr_hi = ^addr[31:ADDR_BITS];

   assign nbytes    = size_bytes(r_size);
   assign last_beat = ({1'b0, beat} == nbytes - 3'd1);
   assign wsel      = 2'(nbytes - 3'd1 - {1'b0, beat});

   load_extend u_load_extend (
      .value    ({shreg, mem_rdata}),
      .size     (r_size),
      .sign_ext (r_sx),
      .result   (ext_val)
   );

   always_comb begin
      state_nx  = state;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req) state_nx = req_bad(size, addr[1:0]) ? ST_ERR : ST_ISSUE;
         end
         ST_ISSUE: begin
            busy      = 1'b1;
            mem_addr  = base + ADDR_BITS'(beat);
            mem_wdata = r_wdata[{wsel, 3'b000} +: 8];
            // A reset arriving mid-beat must not let that beat's byte land in RAM.
            mem_we    = r_we & ~reset;
            if (last_beat) state_nx = r_we ? ST_FIN : ST_DRAIN;
         end
         ST_DRAIN: begin
            busy     = 1'b1;
            state_nx = ST_FIN;
         end
         ST_FIN: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         ST_ERR: begin
            done     = 1'b1;
            err      = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         beat    <= '0;
         base    <= '0;
         r_size  <= SZ_BYTE;
         r_we    <= 1'b0;
         r_sx    <= 1'b0;
         r_wdata <= '0;
         shreg   <= '0;
         rdata   <= '0;
      end else begin
         state <= state_nx;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  base    <= addr[ADDR_BITS-1:0];
                  r_size  <= size;
                  r_we    <= we;
                  r_sx    <= sign_ext;
                  r_wdata <= wdata;
                  beat    <= '0;
                  shreg   <= '0;
               end
            end
            ST_ISSUE: begin
               beat <= beat + 2'd1;
               // mem_rdata now carries the byte addressed by the previous beat.
               if (!r_we && beat != 2'd0) shreg <= {shreg[15:0], mem_rdata};
            end
            ST_DRAIN: rdata <= ext_val;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_seq.sv
// tb/tb_mem_access_seq.sv - randomized bench for mem_access_seq against a byte-array reference model
module tb_mem_access_seq;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset, req, we, sign_ext;
   logic [1:0]  size;
   logic [31:0] addr, wdata, rdata;
   logic        busy, done, err;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;

   logic [7:0]  ram     [256];
   logic [7:0]  ref_mem [256];
   logic        bd_en = 1'b0;
   logic [7:0]  bd_a, bd_d;
   logic [31:0] rdata_exp;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_access_seq #(.ADDR_BITS(8), .RD_LAT(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .we        (we),
      .size      (size),
      .sign_ext  (sign_ext),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata)
   );

   always @(posedge clk) begin
      if (bd_en) ram[bd_a] <= bd_d;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      bd_en = 1'b1; bd_a = a; bd_d = d;
      ref_mem[a] = d;
      @(negedge clk);
      bd_en = 1'b0;
   endtask

   task automatic run_txn(input logic t_we, input logic [1:0] t_size, input logic t_sx,
                          input logic [31:0] t_addr, input logic [31:0] t_wdata,
                          input bit hold_req, input string tag);
      int nb, lat, done_at, busy_bad, done_bad, err_bad, addr_bad, we_bad, wd_bad;
      logic bad;
      logic [31:0] v;
      nb  = (t_size == SZ_BYTE) ? 1 : (t_size == SZ_HALF) ? 2 : 4;
      bad = (t_size == SZ_RSVD) || (t_size == SZ_HALF && t_addr[0]) ||
            (t_size == SZ_WORD && t_addr[1:0] != 2'b00);
      lat = bad ? 1 : (t_we ? nb + 1 : nb + 2);
      if (!bad && !t_we) begin
         v = 0;
         for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_mem[(t_addr + 32'(i)) & 32'hFF]);
         if (nb < 4 && t_sx && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
      end else begin
         v = rdata_exp;
      end
      done_at = 0; busy_bad = 0; done_bad = 0; err_bad = 0; addr_bad = 0; we_bad = 0; wd_bad = 0;
      @(negedge clk);
      req = 1'b1; we = t_we; size = t_size; sign_ext = t_sx; addr = t_addr; wdata = t_wdata;
      @(posedge clk);
      for (int c = 1; c <= lat + 1; c++) begin
         @(negedge clk);
         if (c == 1) begin
            if (!hold_req) req = 1'b0;
            addr = $urandom; wdata = $urandom; we = 1'($urandom);
            size = 2'($urandom); sign_ext = 1'($urandom);
         end
         if (busy !== (!bad && c <= lat)) busy_bad++;
         if (done !== (c == lat)) done_bad++;
         if (done === 1'b1 && done_at == 0) done_at = c;
         if (err !== (bad && c == lat)) err_bad++;
         if (!bad && c <= nb) begin
            if (mem_addr !== 8'(t_addr + 32'(c - 1))) addr_bad++;
            if (mem_we !== t_we) we_bad++;
            if (t_we && mem_wdata !== t_wdata[8*(nb-c) +: 8]) wd_bad++;
         end else if (mem_we !== 1'b0) begin
            we_bad++;
         end
         if (c == lat) begin
            rdata_exp = v;
            chk({tag, "_rdata"}, rdata, rdata_exp);
         end
         if (c == lat + 1) begin
            req = 1'b0;
            chk({tag, "_rdata_hold"}, rdata, rdata_exp);
         end
      end
      chk({tag, "_done_at"}, 32'(done_at), 32'(lat));
      chk({tag, "_done_pat"}, 32'(done_bad), 0);
      chk({tag, "_busy_pat"}, 32'(busy_bad), 0);
      chk({tag, "_err_pat"}, 32'(err_bad), 0);
      chk({tag, "_addr_seq"}, 32'(addr_bad), 0);
      chk({tag, "_we_seq"}, 32'(we_bad), 0);
      chk({tag, "_wdata_seq"}, 32'(wd_bad), 0);
      if (t_we && !bad) begin
         for (int i = 0; i < nb; i++) begin
            ref_mem[(t_addr + 32'(i)) & 32'hFF] = t_wdata[8*(nb-1-i) +: 8];
            chk({tag, "_ram"}, 32'(ram[(t_addr + 32'(i)) & 32'hFF]),
                32'(ref_mem[(t_addr + 32'(i)) & 32'hFF]));
         end
      end
   endtask

   initial begin
      logic [1:0]  r_size;
      logic [31:0] r_addr;
      int mism;
      reset = 1'b1; req = 1'b0; we = 1'b0; size = SZ_BYTE; sign_ext = 1'b0;
      addr = '0; wdata = '0; rdata_exp = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      chk("rst_rdata", rdata, 0);
      reset = 1'b0;
      for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));

      poke(8'd16, 8'hDE); poke(8'd17, 8'hAD); poke(8'd18, 8'hBE); poke(8'd19, 8'hEF);
      run_txn(1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0, 1'b0, "ld_w10");
      chk("ld_w10_const", rdata, 32'hDEADBEEF);

      run_txn(1'b1, SZ_WORD, 1'b0, 32'h0000_0020, 32'h12345678, 1'b0, "st_w20");
      run_txn(1'b0, SZ_WORD, 1'b1, 32'h0000_0020, 32'h0, 1'b0, "ld_w20");
      chk("ld_w20_const", rdata, 32'h12345678);

      poke(VEC_253, 8'h80);
      run_txn(1'b0, SZ_BYTE, 1'b1, 32'(VEC_253), 32'h0, 1'b0, "ld_b253s");
      chk("ld_b253s_const", rdata, 32'hFFFFFF80);
      run_txn(1'b0, SZ_BYTE, 1'b0, 32'(VEC_253), 32'h0, 1'b0, "ld_b253z");
      chk("ld_b253z_const", rdata, 32'h00000080);

      poke(VEC_254, 8'h7F); poke(VEC_255, 8'h01);
      run_txn(1'b0, SZ_HALF, 1'b1, 32'(VEC_254), 32'h0, 1'b0, "ld_h254");
      chk("ld_h254_const", rdata, 32'h00007F01);
      run_txn(1'b0, SZ_WORD, 1'b0, 32'h0000_01FC, 32'h0, 1'b1, "ld_w1fc");

      run_txn(1'b1, SZ_WORD, 1'b0, 32'h0000_0022, 32'hCAFEF00D, 1'b0, "err_w22");
      run_txn(1'b0, SZ_HALF, 1'b1, 32'h0000_0033, 32'h0, 1'b1, "err_h33");
      run_txn(1'b1, SZ_RSVD, 1'b0, 32'h0000_0040, 32'h55AA55AA, 1'b1, "err_rsvd");

      // Reset during beat 2 of a word store with req held high throughout.
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = SZ_WORD; sign_ext = 1'b0; addr = 32'h40; wdata = 32'hA1B2C3D4;
      @(posedge clk);
      @(negedge clk);
      chk("rstmid_beat0_addr", 32'(mem_addr), 32'h40);
      @(negedge clk);
      chk("rstmid_beat1_addr", 32'(mem_addr), 32'h41);
      @(negedge clk);
      chk("rstmid_beat2_addr", 32'(mem_addr), 32'h42);
      chk("rstmid_beat2_busy", 32'(busy), 1);
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rstmid_busy", 32'(busy), 0);
         chk("rstmid_done", 32'(done), 0);
         chk("rstmid_err", 32'(err), 0);
         chk("rstmid_mem_we", 32'(mem_we), 0);
         chk("rstmid_mem_addr", 32'(mem_addr), 0);
         chk("rstmid_mem_wdata", 32'(mem_wdata), 0);
         chk("rstmid_rdata", rdata, 0);
      end
      reset = 1'b0; req = 1'b0; rdata_exp = '0;
      ref_mem[8'h40] = 8'hA1; ref_mem[8'h41] = 8'hB2;
      for (int i = 0; i < 4; i++) chk("rstmid_ram", 32'(ram[8'h40 + i]), 32'(ref_mem[8'h40 + i]));

      for (int t = 0; t < 60; t++) begin
         r_size = 2'($urandom_range(3));
         r_addr = $urandom;
         if ($urandom_range(3) != 0) begin
            if (r_size == SZ_HALF) r_addr[0] = 1'b0;
            if (r_size == SZ_WORD) r_addr[1:0] = 2'b00;
         end
         run_txn(1'($urandom), r_size, 1'($urandom), r_addr, $urandom,
                 bit'($urandom_range(1)), $sformatf("rnd%0d", t));
      end

      mism = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) mism++;
      chk("ram_final", 32'(mism), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
